mem_burst_v3: RTL



---
 rtl/mem_burst_v3.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_burst_v3.sv
// Burst engine between user read/write burst ports and the DDR2 controller local interface.
// Splits user bursts into local commands of up to BURST_SIZE beats, alternates read/write on contention.
module mem_burst_v3 #(
  parameter int MEM_DATA_BITS   = 64,
  parameter int ADDR_BITS       = 24,
  parameter int LOCAL_SIZE_BITS = 3,
  parameter int BURST_SIZE      = 2,
  parameter int LEN_BITS        = 10,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       mem_clk,
  input  logic                       rst,
  input  logic                       rd_burst_req,
  input  logic [LEN_BITS-1:0]        rd_burst_len,
  input  logic [ADDR_BITS-1:0]       rd_burst_addr,
  output logic                       rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
  output logic                       rd_burst_finish,
  output logic                       rd_burst_error,
  input  logic                       wr_burst_req,
  input  logic [LEN_BITS-1:0]        wr_burst_len,
  input  logic [ADDR_BITS-1:0]       wr_burst_addr,
  output logic                       wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0]   wr_burst_data,
  input  logic [MEM_DATA_BITS/8-1:0] wr_burst_be,
  output logic                       wr_burst_finish,
  output logic                       burst_finish,
  input  logic                       local_init_done,
  input  logic                       local_ready,
  output logic                       local_burstbegin,
  output logic [ADDR_BITS-1:0]       local_address,
  output logic [LOCAL_SIZE_BITS-1:0] local_size,
  output logic                       local_read_req,
  output logic                       local_write_req,
  output logic [MEM_DATA_BITS-1:0]   local_wdata,
  output logic [MEM_DATA_BITS/8-1:0] local_be,
  input  logic                       local_rdata_valid,
  input  logic [MEM_DATA_BITS-1:0]   local_rdata
);

  // state   | meaning
  // IDLE    | arbitrate between pending read and write requests
  // RD_CMD  | issue read commands until the whole burst is requested
  // RD_WAIT | all read commands issued, collect returning beats under watchdog
  // WR_BEAT | stream write beats, one local burst at a time
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_BEAT} state_t;

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   TO_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_BITS-1:0] BS_L    = LEN_BITS'(BURST_SIZE);

  state_t state, state_nxt;
  logic                       last_grant_wr;
  logic [ADDR_BITS-1:0]       cmd_addr;
  logic [LEN_BITS-1:0]        remaining, total, rd_cnt;
  logic [LOCAL_SIZE_BITS-1:0] beat_in_burst, wr_size, rd_size;
  logic [IDLE_W-1:0]          idle_cnt;
  logic rd_ok, wr_ok, grant_rd, grant_wr, in_rd, rd_beat, rd_last, timeout;
  logic cmd_accept, beat_accept, wr_last, burst_end;

  function automatic logic [LOCAL_SIZE_BITS-1:0] clip_size(input logic [LEN_BITS-1:0] r);
    return (r < BS_L) ? LOCAL_SIZE_BITS'(r) : LOCAL_SIZE_BITS'(BURST_SIZE);
  endfunction

  assign rd_ok       = rd_burst_req && (rd_burst_len != '0);
  assign wr_ok       = wr_burst_req && (wr_burst_len != '0);
  assign grant_rd    = local_init_done && (state == IDLE) && rd_ok && (!wr_ok || last_grant_wr);
  assign grant_wr    = local_init_done && (state == IDLE) && wr_ok && !grant_rd;
  assign in_rd       = local_init_done && ((state == RD_CMD) || (state == RD_WAIT));
  assign rd_beat     = in_rd && local_rdata_valid;
  assign rd_last     = rd_beat && (rd_cnt == total - LEN_BITS'(1));
  assign timeout     = local_init_done && (state == RD_WAIT) && !local_rdata_valid && (idle_cnt == TO_LAST);
  assign rd_size     = clip_size(remaining);
  assign cmd_accept  = local_init_done && (state == RD_CMD) && local_ready;
  assign beat_accept = local_init_done && (state == WR_BEAT) && local_ready;
  assign wr_last     = beat_accept && (remaining == LEN_BITS'(1));
  assign burst_end   = beat_accept && ((beat_in_burst + LOCAL_SIZE_BITS'(1)) == wr_size);

  always_ff @(posedge mem_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!local_init_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (grant_rd) state_nxt = RD_CMD;
                 else if (grant_wr) state_nxt = WR_BEAT;
        RD_CMD:  if (rd_last) state_nxt = IDLE;
                 else if (cmd_accept && (remaining == LEN_BITS'(rd_size))) state_nxt = RD_WAIT;
        RD_WAIT: if (rd_last || timeout) state_nxt = IDLE;
        WR_BEAT: if (wr_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      last_grant_wr <= 1'b1;
      cmd_addr      <= '0;
      remaining     <= '0;
      total         <= '0;
      rd_cnt        <= '0;
      beat_in_burst <= '0;
      wr_size       <= '0;
      idle_cnt      <= '0;
    end else if (!local_init_done) begin
      remaining     <= '0;
      total         <= '0;
      rd_cnt        <= '0;
      beat_in_burst <= '0;
      wr_size       <= '0;
      idle_cnt      <= '0;
    end else begin
      idle_cnt <= ((state == RD_WAIT) && !local_rdata_valid) ? idle_cnt + IDLE_W'(1) : '0;
      if (grant_rd || grant_wr) begin
        cmd_addr      <= grant_rd ? rd_burst_addr : wr_burst_addr;
        remaining     <= grant_rd ? rd_burst_len : wr_burst_len;
        total         <= grant_rd ? rd_burst_len : wr_burst_len;
        rd_cnt        <= '0;
        beat_in_burst <= '0;
        wr_size       <= clip_size(wr_burst_len);
        last_grant_wr <= grant_wr;
      end
      if (cmd_accept) begin
        cmd_addr  <= cmd_addr + ADDR_BITS'(rd_size);
        remaining <= remaining - LEN_BITS'(rd_size);
      end
      if (rd_beat) rd_cnt <= rd_cnt + LEN_BITS'(1);
      if (beat_accept) begin
        remaining <= remaining - LEN_BITS'(1);
        if (burst_end) begin
          // next local burst starts after this one; its size comes from what is left
          beat_in_burst <= '0;
          cmd_addr      <= cmd_addr + ADDR_BITS'(wr_size);
          wr_size       <= clip_size(remaining - LEN_BITS'(1));
        end else begin
          beat_in_burst <= beat_in_burst + LOCAL_SIZE_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    local_burstbegin  = 1'b0;
    local_read_req    = 1'b0;
    local_write_req   = 1'b0;
    local_size        = '0;
    wr_burst_data_req = 1'b0;
    local_be          = '1;
    if (local_init_done) begin
      case (state)
        RD_CMD: begin
          local_read_req   = 1'b1;
          local_burstbegin = 1'b1;
          local_size       = rd_size;
        end
        WR_BEAT: begin
          local_write_req   = 1'b1;
          local_burstbegin  = (beat_in_burst == '0);
          local_size        = wr_size;
          wr_burst_data_req = local_ready;
          local_be          = wr_burst_be;
        end
        default: ;
      endcase
    end
  end

  assign local_address       = cmd_addr;
  assign local_wdata         = wr_burst_data;
  assign rd_burst_data_valid = rd_beat;
  assign rd_burst_data       = in_rd ? local_rdata : '0;
  assign rd_burst_finish     = rd_last;
  assign rd_burst_error      = timeout;
  assign wr_burst_finish     = wr_last;
  assign burst_finish        = rd_last | wr_last;

endmodule
